// File: rtl/seq_divider_addsub_pkg.sv
// Shared encodings and constants for the sequential restoring divider.
package seq_divider_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StBusy = ST_BUSY,
    StDone = ST_DONE
  } state_e;

  // Quotient reported on divide-by-zero; sliced to the operand width by users.
  localparam logic [31:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_addsub_div_trial_sub.sv
// N-bit trial subtractor a - b built as the add/sub datapath with M tied to 1
// (b inverted, carry-in 1), carries produced by two-level lookahead.
module div_trial_sub #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N-1:0] b_inv;
  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;

  assign b_inv = ~b;
  assign p     = a ^ b_inv;
  assign g     = a & b_inv;

  // Each carry is expanded from g/p terms and the carry-in, not from c[i].
  always_comb begin
    logic pp;
    c    = '0;
    pp   = 1'b0;
    c[0] = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | pp;
    end
  end

  assign diff      = p ^ c[N-1:0];
  assign no_borrow = c[N];

endmodule

// File: rtl/seq_divider_addsub.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (one extra cycle of latency).
module seq_divider_addsub
  import seq_divider_addsub_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  quotient_q, quotient_d;
  logic [W-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [2*W:0]  rq_shift;
  logic [W:0]    trial_diff;
  logic          trial_ok;
  logic [W:0]    rem_next;
  logic [W-1:0]  quo_next;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
  logic fix_q, fix_d;

  assign op_a = dividend[W-1] ? (~dividend + W'(1)) : dividend;
  assign op_b = divisor[W-1]  ? (~divisor + W'(1))  : divisor;
`else
  assign op_a = dividend;
  assign op_b = divisor;
`endif

  // The top bit of R falls off the shift; it is always zero since R < divisor.
  assign rq_shift = {rem_q, quo_q} << 1;

  div_trial_sub #(
    .N(W + 1)
  ) u_trial (
    .a        (rq_shift[2*W:W]),
    .b        ({1'b0, dvs_q}),
    .diff     (trial_diff),
    .no_borrow(trial_ok)
  );

  assign rem_next = trial_ok ? trial_diff : rq_shift[2*W:W];
  assign quo_next = rq_shift[W-1:0] | W'(trial_ok);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    fix_d       = fix_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            quotient_d  = DBZ_QUOTIENT[W-1:0];
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = StBusy;
            rem_d   = '0;
            quo_d   = op_a;
            dvs_d   = op_b;
            cnt_d   = CW'(W);
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_d = dividend[W-1] ^ divisor[W-1];
            r_neg_d = dividend[W-1];
`endif
          end
        end
      end

      StBusy: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
`ifdef SEQ_DIVIDER_SIGNED_EN
          fix_d       = 1'b1;
`else
          out_valid_d = 1'b1;
          quotient_d  = quo_next;
          remainder_d = rem_next[W-1:0];
          dbz_d       = 1'b0;
`endif
        end
      end

      StDone: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        // Sign correction happens in the first DONE cycle, before out_valid.
        if (fix_q) begin
          fix_d       = 1'b0;
          out_valid_d = 1'b1;
          quotient_d  = q_neg_q ? (~quo_q + W'(1)) : quo_q;
          remainder_d = r_neg_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
          dbz_d       = 1'b0;
        end else
`endif
        if (out_valid_q && out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      fix_q   <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      fix_q   <= fix_d;
    end
  end
`endif

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_addsub.sv
// Bench for seq_divider_addsub: W=4 and W=8 instances checked every cycle against an
// arithmetic reference model, plus directed operations with literal expectations.
module tb_seq_divider_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] iv;
  logic [1:0] ordy;
  logic [3:0] a4, b4, q4, r4;
  logic [7:0] a8, b8, q8, r8;
  logic       ir4, ov4, dz4, ir8, ov8, dz8;

  seq_divider_addsub #(.W(4), .CW(6)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir4), .dividend(a4), .divisor(b4),
    .out_valid(ov4), .out_ready(ordy[0]), .quotient(q4), .remainder(r4), .div_by_zero(dz4)
  );

  seq_divider_addsub #(.W(8), .CW(6)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir8), .dividend(a8), .divisor(b8),
    .out_valid(ov8), .out_ready(ordy[1]), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state, one slot per instance (0: W=4, 1: W=8).
  int m_st[2], m_wait[2], m_q[2], m_r[2], p_q[2], p_r[2];
  bit m_ir[2], m_ov[2], m_dz[2];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int width(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  // Edges from the accepting cycle until out_valid is visible, counting the accept cycle.
  function automatic int elat(input int w);
`ifdef SEQ_DIVIDER_SIGNED_EN
    return w + 2;
`else
    return w + 1;
`endif
  endfunction

  function automatic int in_a(input int d);
    return (d == 0) ? int'(a4) : int'(a8);
  endfunction
  function automatic int in_b(input int d);
    return (d == 0) ? int'(b4) : int'(b8);
  endfunction
  function automatic int out_q(input int d);
    return (d == 0) ? int'(q4) : int'(q8);
  endfunction
  function automatic int out_r(input int d);
    return (d == 0) ? int'(r4) : int'(r8);
  endfunction
  function automatic int out_v(input int d);
    return (d == 0) ? int'(ov4) : int'(ov8);
  endfunction
  function automatic int out_dz(input int d);
    return (d == 0) ? int'(dz4) : int'(dz8);
  endfunction
  function automatic int in_rdy(input int d);
    return (d == 0) ? int'(ir4) : int'(ir8);
  endfunction

  task automatic ref_div(input int w, input int a_in, input int b_in,
                         output int q, output int r, output bit dz);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int mask, a, b, sa, sb;
    mask = (1 << w) - 1;
    a  = a_in & mask;
    b  = b_in & mask;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    dz = (b == 0);
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (sa == -(1 << (w - 1)) && sb == -1) begin
      q = a;
      r = 0;
    end else begin
      q = (sa / sb) & mask;
      r = (sa % sb) & mask;
    end
`else
    int mask, a, b;
    mask = (1 << w) - 1;
    a  = a_in & mask;
    b  = b_in & mask;
    dz = (b == 0);
    if (b == 0) begin
      q = mask;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endtask

  // Model phases: 0 idle, 1 computing, 2 result offered.
  task automatic model_step(input int d);
    int q, r;
    bit dz;
    if (rst) begin
      m_st[d] = 0; m_ir[d] = 1'b1; m_ov[d] = 1'b0;
      m_q[d] = 0; m_r[d] = 0; m_dz[d] = 1'b0; m_wait[d] = 0;
    end else begin
      case (m_st[d])
        0: if (iv[d]) begin
          ref_div(width(d), in_a(d), in_b(d), q, r, dz);
          m_ir[d] = 1'b0;
          if (dz) begin
            m_st[d] = 2; m_ov[d] = 1'b1; m_q[d] = q; m_r[d] = r; m_dz[d] = 1'b1;
          end else begin
            m_st[d] = 1; m_wait[d] = elat(width(d)) - 1; p_q[d] = q; p_r[d] = r;
          end
        end
        1: begin
          m_wait[d]--;
          if (m_wait[d] == 0) begin
            m_st[d] = 2; m_ov[d] = 1'b1; m_q[d] = p_q[d]; m_r[d] = p_r[d]; m_dz[d] = 1'b0;
          end
        end
        default: if (ordy[d]) begin
          m_st[d] = 0; m_ov[d] = 1'b0; m_ir[d] = 1'b1;
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("model.d%0d.in_ready", d), in_rdy(d), int'(m_ir[d]));
        check($sformatf("model.d%0d.out_valid", d), out_v(d), int'(m_ov[d]));
        check($sformatf("model.d%0d.quotient", d), out_q(d), m_q[d]);
        check($sformatf("model.d%0d.remainder", d), out_r(d), m_r[d]);
        check($sformatf("model.d%0d.div_by_zero", d), out_dz(d), int'(m_dz[d]));
      end
    end
  end

  task automatic set_ops(input int d, input int a, input int b);
    if (d == 0) begin
      a4 = 4'(a);
      b4 = 4'(b);
    end else begin
      a8 = 8'(a);
      b8 = 8'(b);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One operation: present, wait (bounded) for the result, check it, optionally stall
  // the consumer while offering new operands, then complete the output handshake.
  task automatic do_op(input int d, input int a, input int b, input int hold,
                       input int eq, input int er, input int edz, input string tag);
    int n;
    set_ops(d, a, b);
    iv[d] = 1'b1;
    step();
    iv[d] = 1'b0;
    n = 0;
    while (out_v(d) == 0 && n < 40) begin
      step();
      n++;
    end
    check({tag, ".latency"}, n + 1, (edz != 0) ? 1 : elat(width(d)));
    check({tag, ".quotient"}, out_q(d), eq);
    check({tag, ".remainder"}, out_r(d), er);
    check({tag, ".div_by_zero"}, out_dz(d), edz);
    if (hold > 0) begin
      set_ops(d, 7, 2);
      iv[d] = 1'b1;
      repeat (hold) step();
      check({tag, ".held_in_ready"}, in_rdy(d), 0);
      check({tag, ".held_out_valid"}, out_v(d), 1);
      check({tag, ".held_quotient"}, out_q(d), eq);
      check({tag, ".held_remainder"}, out_r(d), er);
    end
    ordy[d] = 1'b1;
    step();
    ordy[d] = 1'b0;
    iv[d]   = 1'b0;
    check({tag, ".idle_in_ready"}, in_rdy(d), 1);
    check({tag, ".idle_out_valid"}, out_v(d), 0);
    check({tag, ".kept_quotient"}, out_q(d), eq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("reset.in_ready", int'(ir4), 1);
    check("reset.out_valid", int'(ov4), 0);
    check("reset.quotient", int'(q8), 0);
    check("reset.remainder", int'(r8), 0);
    step();

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_op(0, 4'b1001, 2, 0, 4'b1101, 4'b1111, 0, "s_m7_div_2");
    do_op(0, 4'b1000, 4'b1111, 0, 4'b1000, 0, 0, "s_m8_div_m1");
    do_op(0, 5, 4'b1110, 0, 4'b1110, 1, 0, "s_5_div_m2");
`else
    do_op(0, 13, 3, 0, 4, 1, 0, "u_13_div_3");
    do_op(1, 200, 201, 0, 0, 200, 0, "u_200_div_201");
    do_op(1, 173, 1, 0, 173, 0, 0, "u_173_div_1");
    do_op(1, 129, 130, 0, 0, 129, 0, "u_129_div_130");
`endif
    do_op(0, 9, 0, 0, 15, 9, 1, "dbz_9");
    do_op(1, 255, 255, 0, 1, 0, 0, "x_255_div_255");
    do_op(0, 6, 3, 5, 2, 0, 0, "hold_6_div_3");
    do_op(0, 7, 2, 0, 3, 1, 0, "after_hold_7_div_2");

    // Reset during the third BUSY cycle of 100/7 discards the operation.
    set_ops(1, 100, 7);
    iv[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.in_ready", int'(ir8), 1);
    check("midrst.out_valid", int'(ov8), 0);
    check("midrst.quotient", int'(q8), 0);
    check("midrst.remainder", int'(r8), 0);
    check("midrst.div_by_zero", int'(dz8), 0);
    repeat (12) step();
    check("midrst.no_late_valid", int'(ov8), 0);
    do_op(1, 100, 7, 0, 14, 2, 0, "x_100_div_7");

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
